flag_branch_unit: RTL and testbench

Execute-stage neighbour that consumes the 16-bit ALU result and overflow indication and maintains the architectural N/Z/V flag register. It also resolves conditional branches from decode against those flags, forwarding the flags of the instruction currently in execute. Outputs are registered, and the unit enters a halted state when HLT reaches execute.

---
 rtl/wisc_pkg.sv | 61 ++++++
 rtl/cond_eval.sv | 25 ++
 rtl/flag_branch_unit.sv | 88 ++++++++
 tb/tb_flag_branch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared WISC types used by the execute-stage flag/branch logic
// and by the fetch-side branch predictor.
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LLB    = 4'b1010,
    OP_LHB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    CC_NE     = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OV     = 3'b110,
    CC_UNCOND = 3'b111
  } ccc_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fbu_state_t;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_Z,
    WR_NZV
  } wr_class_t;

  // Which flag bits an opcode is allowed to overwrite.
  function automatic wr_class_t writer_class(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB:                 writer_class = WR_NZV;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: writer_class = WR_Z;
      default:                        writer_class = WR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: (flags, condition code) -> taken.
module cond_eval
  import wisc_pkg::*;
(
  input  flags_t f,
  input  ccc_t   ccc,
  output logic   taken
);

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:     taken = ~f.z;
      CC_EQ:     taken = f.z;
      CC_GT:     taken = ~f.z & ~f.n;
      CC_LT:     taken = f.n;
      CC_GTE:    taken = f.z | (~f.z & ~f.n);
      CC_LTE:    taken = f.n | f.z;
      CC_OV:     taken = f.v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural N/Z/V flag register with same-cycle bypass into the
// conditional-branch resolver; halts when HLT commits.
module flag_branch_unit
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovfl,
  input  logic              stall,
  input  logic              flush,
  input  logic              br_valid,
  input  logic [2:0]        br_ccc,
  output logic [2:0]        flags,
  output logic              br_resolved,
  output logic              br_taken,
  output logic              halted
);

  opcode_t    op;
  fbu_state_t state_q, state_d;
  flags_t     flags_q, flags_d;
  logic       br_resolved_q, br_resolved_d;
  logic       br_taken_q, br_taken_d;
  logic       run, ex_fire, br_accept, cond_taken;
  logic [2:0] wr_mask, cand_vec, cur_vec, next_vec;

  always_comb begin
    op        = opcode_t'(ex_opcode);
    run       = (state_q == RUN);
    ex_fire   = ex_valid & ~flush & ~stall & run;
    br_accept = br_valid & ~stall & run;
    cand_vec  = {alu_result[DATA_W-1], ~|alu_result, alu_ovfl};
    cur_vec   = flags_q;
    wr_mask   = 3'b000;
    if (ex_fire) begin
      case (writer_class(op))
        WR_NZV:  wr_mask = 3'b111;
        WR_Z:    wr_mask = 3'b010;
        default: wr_mask = 3'b000;
      endcase
    end
  end

  // Per-bit merge: this vector is both the next committed value and the bypass.
  for (genvar gi = 0; gi < 3; gi++) begin : g_merge
    assign next_vec[gi] = wr_mask[gi] ? cand_vec[gi] : cur_vec[gi];
  end

  cond_eval u_cond_eval (
    .f     (flags_t'(next_vec)),
    .ccc   (ccc_t'(br_ccc)),
    .taken (cond_taken)
  );

  always_comb begin
    flags_d       = flags_t'(next_vec);
    state_d       = state_q;
    br_resolved_d = br_accept;
    br_taken_d    = br_taken_q;
    if (br_accept) br_taken_d = cond_taken;
    if (ex_fire && op == OP_HLT) state_d = HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flags_q       <= '0;
      br_resolved_q <= 1'b0;
      br_taken_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      br_resolved_q <= br_resolved_d;
      br_taken_q    <= br_taken_d;
    end
  end

  assign flags       = flags_q;
  assign br_resolved = br_resolved_q;
  assign br_taken    = br_taken_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: directed scenarios plus a
// randomized run checked against a rule-level reference model.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_opcode = 4'h0;
  logic [15:0] alu_result = 16'h0;
  logic        alu_ovfl = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_ccc = 3'b0;
  logic [2:0]  flags;
  logic        br_resolved, br_taken, halted;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic       m_n, m_z, m_v, m_halted, m_res, m_taken;

  flag_branch_unit #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl), .stall(stall), .flush(flush),
    .br_valid(br_valid), .br_ccc(br_ccc), .flags(flags),
    .br_resolved(br_resolved), .br_taken(br_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic cond_ok(input logic n, input logic z, input logic v,
                                   input logic [2:0] c);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Advance the model by the rules for the current inputs, then clock the DUT.
  task automatic cycle();
    logic nn, nz, nv, upd;
    upd = ex_valid && !flush && !stall && !m_halted;
    nn = m_n; nz = m_z; nv = m_v;
    if (upd && (ex_opcode == 4'd0 || ex_opcode == 4'd1)) begin
      nn = alu_result[15]; nz = (alu_result == 16'd0); nv = alu_ovfl;
    end else if (upd && (ex_opcode == 4'd2 || ex_opcode == 4'd4 ||
                         ex_opcode == 4'd5 || ex_opcode == 4'd6)) begin
      nz = (alu_result == 16'd0);
    end
    if (br_valid && !stall && !m_halted) begin
      m_res = 1'b1; m_taken = cond_ok(nn, nz, nv, br_ccc);
    end else begin
      m_res = 1'b0;
    end
    if (upd && ex_opcode == 4'hF) m_halted = 1'b1;
    m_n = nn; m_z = nz; m_v = nv;
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t ex=%b op=%h res=%h ov=%b st=%b fl=%b br=%b ccc=%0d -> flags=%b res=%b tk=%b hlt=%b",
             $time, ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush,
             br_valid, br_ccc, flags, br_resolved, br_taken, halted);
  endtask

  task automatic drive(input logic ev, input logic [3:0] op, input logic [15:0] res,
                       input logic ov, input logic bv, input logic [2:0] c);
    ex_valid = ev; ex_opcode = op; alu_result = res; alu_ovfl = ov;
    br_valid = bv; br_ccc = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 0; flush = 0;
    drive(0, 4'h0, 16'h0, 0, 0, 3'd0);
    m_n = 0; m_z = 0; m_v = 0; m_halted = 0; m_res = 0; m_taken = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (flags !== 3'b000) $display("FAIL reset_flags got %b want 000", flags); else n_pass++;
    n_checks++; if (br_resolved !== 1'b0) $display("FAIL reset_res got %b want 0", br_resolved); else n_pass++;
    n_checks++; if (br_taken !== 1'b0) $display("FAIL reset_taken got %b want 0", br_taken); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_zero();
    drive(1, 4'h0, 16'h0000, 0, 0, 3'd0); cycle();
    n_checks++; if (flags !== 3'b010) $display("FAIL add_zero_flags got %b want 010", flags); else n_pass++;
  endtask

  task automatic test_sat_bypass();
    drive(1, 4'h0, 16'h7FFF, 1, 1, 3'd6); cycle();
    n_checks++; if (flags !== 3'b001) $display("FAIL sat_flags got %b want 001", flags); else n_pass++;
    n_checks++; if (br_resolved !== 1'b1) $display("FAIL sat_res got %b want 1", br_resolved); else n_pass++;
    n_checks++; if (br_taken !== 1'b1) $display("FAIL sat_taken got %b want 1", br_taken); else n_pass++;
  endtask

  task automatic test_xor_z_only();
    drive(1, 4'h1, 16'h8000, 1, 0, 3'd0); cycle();
    n_checks++; if (flags !== 3'b101) $display("FAIL xor_setup got %b want 101", flags); else n_pass++;
    drive(1, 4'h2, 16'h0000, 0, 0, 3'd0); cycle();
    n_checks++; if (flags !== 3'b111) $display("FAIL xor_flags got %b want 111", flags); else n_pass++;
    drive(0, 4'h0, 16'h0, 0, 1, 3'd2); cycle();
    n_checks++; if (br_resolved !== 1'b1 || br_taken !== 1'b0)
      $display("FAIL xor_gt got res=%b tk=%b want res=1 tk=0", br_resolved, br_taken); else n_pass++;
    drive(0, 4'h0, 16'h0, 0, 1, 3'd5); cycle();
    n_checks++; if (br_resolved !== 1'b1 || br_taken !== 1'b1)
      $display("FAIL xor_lte got res=%b tk=%b want res=1 tk=1", br_resolved, br_taken); else n_pass++;
  endtask

  task automatic test_flush();
    drive(1, 4'h0, 16'h0001, 0, 0, 3'd0); cycle();
    n_checks++; if (flags !== 3'b000) $display("FAIL flush_setup got %b want 000", flags); else n_pass++;
    flush = 1; drive(1, 4'h1, 16'h8000, 0, 1, 3'd3); cycle(); flush = 0;
    n_checks++; if (flags !== 3'b000) $display("FAIL flush_flags got %b want 000", flags); else n_pass++;
    n_checks++; if (br_resolved !== 1'b1 || br_taken !== 1'b0)
      $display("FAIL flush_br got res=%b tk=%b want res=1 tk=0", br_resolved, br_taken); else n_pass++;
  endtask

  task automatic test_stall();
    stall = 1; drive(1, 4'h0, 16'h8000, 0, 1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (flags !== 3'b000 || br_resolved !== 1'b0 || br_taken !== 1'b0)
        $display("FAIL stall_hold got flags=%b res=%b tk=%b want 000/0/0", flags, br_resolved, br_taken);
      else n_pass++;
    end
    stall = 0; cycle();
    n_checks++; if (flags !== 3'b100 || br_resolved !== 1'b1 || br_taken !== 1'b1)
      $display("FAIL stall_release got flags=%b res=%b tk=%b want 100/1/1", flags, br_resolved, br_taken);
    else n_pass++;
    drive(0, 4'h0, 16'h0, 0, 0, 3'd0); cycle();
    n_checks++; if (br_resolved !== 1'b0 || br_taken !== 1'b1)
      $display("FAIL stall_after got res=%b tk=%b want res=0 tk=1", br_resolved, br_taken); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(0, 4'h0, 16'h0, 0, 1, 3'd7); cycle();
    n_checks++; if (br_resolved !== 1'b1 || br_taken !== 1'b1)
      $display("FAIL b2b_first got res=%b tk=%b want 1/1", br_resolved, br_taken); else n_pass++;
    drive(0, 4'h0, 16'h0, 0, 1, 3'd1); cycle();
    n_checks++; if (br_resolved !== 1'b1 || br_taken !== 1'b0)
      $display("FAIL b2b_second got res=%b tk=%b want 1/0", br_resolved, br_taken); else n_pass++;
    drive(0, 4'h0, 16'h0, 0, 0, 3'd0); cycle();
    n_checks++; if (br_resolved !== 1'b0) $display("FAIL b2b_end got res=%b want 0", br_resolved); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: r = 16'h0000;
        1: r = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        default: r = 16'($urandom);
      endcase
      drive(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 14)), r,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 2);
      cycle();
      n_checks++; if (flags !== {m_n, m_z, m_v} || br_resolved !== m_res ||
                      br_taken !== m_taken || halted !== m_halted)
        $display("FAIL rand_%0d got f=%b r=%b t=%b h=%b want f=%b r=%b t=%b h=%b", i,
                 flags, br_resolved, br_taken, halted, {m_n, m_z, m_v}, m_res, m_taken, m_halted);
      else n_pass++;
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_halt();
    logic [2:0] frozen;
    drive(1, 4'hF, 16'h0, 0, 1, 3'd7); cycle();
    n_checks++; if (halted !== 1'b1 || br_resolved !== 1'b1 || br_taken !== 1'b1)
      $display("FAIL halt_enter got h=%b r=%b t=%b want 1/1/1", halted, br_resolved, br_taken); else n_pass++;
    frozen = {m_n, m_z, m_v};
    drive(1, 4'h0, 16'h0000, 1, 1, 3'd7); cycle();
    n_checks++; if (flags !== frozen || br_resolved !== 1'b0 || halted !== 1'b1)
      $display("FAIL halt_frozen got f=%b r=%b h=%b want f=%b r=0 h=1", flags, br_resolved, halted, frozen);
    else n_pass++;
    drive(0, 4'h0, 16'h0, 0, 0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (flags !== 3'b000 || halted !== 1'b0 || br_taken !== 1'b0)
      $display("FAIL async_reset got f=%b h=%b t=%b want 000/0/0", flags, halted, br_taken); else n_pass++;
    m_n = 0; m_z = 0; m_v = 0; m_halted = 0; m_res = 0; m_taken = 0;
    @(negedge clk); rst_n = 1'b1;
    drive(1, 4'h0, 16'hFFF0, 0, 0, 3'd0); cycle();
    n_checks++; if (flags !== 3'b100 || halted !== 1'b0)
      $display("FAIL post_reset got f=%b h=%b want 100/0", flags, halted); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_zero();
    test_sat_bypass();
    test_xor_z_only();
    test_flush();
    test_stall();
    test_back_to_back();
    test_random();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
